uart_transmitter: RTL and testbench
===================================

# uart_transmitter

8N1 UART transmitter that serialises bytes from a parallel producer onto the serial line consumed by the UART receiver stage. A 4-entry byte FIFO decouples the producer from the bit timer, so several bytes can be queued and sent back-to-back with no idle gap. It is the upstream peer of the receiver: same bit timing, same frame format, LSB first, one start bit, one stop bit, no parity.

## Interface
- CLOCKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200 bps); legal range 2..255
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  producer offers tx_data this cycle
- tx_ready  out  1  FIFO can accept a byte; equals (fifo_count != FIFO_DEPTH)
- dataserial  out  1  serial line, registered; idles high
- tx_busy  out  1  high while a frame is being driven (START, DATABIT or STOP)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes queued but not yet started

## Operation
- Push: a byte is written on an edge where tx_valid && tx_ready. tx_data must be held until accepted.
- Pop: the FSM takes the head byte into the shift register on the edge it enters START.
- If a push and a pop occur on the same edge, fifo_count is unchanged and both take effect.
- While full, tx_ready=0 and the producer is not accepted. A pop in that cycle raises tx_ready on the next cycle.
- FSM states:
  - IDLE: dataserial=1. If fifo_count!=0, go to START and pop.
  - START: dataserial=0 for CLOCKS_PER_BIT cycles, then go to DATABIT with index=0.
  - DATABIT: dataserial=shift[index] for CLOCKS_PER_BIT cycles, LSB first. After index 7, go to STOP.
  - STOP: dataserial=1 for CLOCKS_PER_BIT cycles. At the end, go to START and pop if fifo_count!=0, otherwise go to IDLE.
- Bit counter: counts 0..CLOCKS_PER_BIT-1 and clears on every bit boundary. Width is $clog2(CLOCKS_PER_BIT) (8 bits at the default); it never wraps mid-bit.
- index is 3 bits and is cleared on entry to DATABIT.
- Reset:
  - state=IDLE, dataserial=1, tx_busy=0.
  - FIFO flushed: fifo_count=0, so tx_ready=1. Pushes on a reset edge are discarded.
  - Reset mid-frame truncates the frame: the line is high after the reset edge and no partial byte is resumed.

## Timing
- A byte accepted at edge E0 into an empty FIFO, with the FSM in IDLE: the FSM pops it at E1, and dataserial falls and tx_busy rises after E1.
- The start bit begins after E1 + CLOCKS_PER_BIT·0. Bit n (0..7) begins after E1 + CLOCKS_PER_BIT·(n+1). The stop bit begins after E1 + 9·CLOCKS_PER_BIT.
- Frame length is exactly 10·CLOCKS_PER_BIT cycles.
- Back-to-back: the next start bit immediately follows the stop bit, with zero idle cycles.
- tx_busy falls on the edge that enters IDLE.
- fifo_count and tx_ready update one edge after the push or pop.
- dataserial is a flop output with no combinational path from any input.

## Structure
- Shared package `uart_pkg`:
  - state encoding IDLE=2'b00, START=2'b01, DATABIT=2'b10, STOP=2'b11, matching the receiver.
  - default CLOCKS_PER_BIT=217.
  - DATA_BITS=8.
- Sub-module `uart_tx_fifo`: synchronous FIFO with read/write pointers, count, full and empty, reset on rst. Parameterised by width and depth, reusable on the receive side.
- The top level holds the FSM, bit counter, index and shift register.

## Test plan
- Single byte 0xA5 from reset → dataserial low one cycle after acceptance. Bits observed are 0,1,0,1,0,0,1,0,1,1, each held 217 cycles, then idle high. tx_busy is high for 2170 cycles.
- Loopback into the receiver, bytes 0x00, 0xFF, 0x55, 0x80 → receiver dataouts match each byte in order.
- Push 5 bytes on consecutive cycles → all 5 accepted (the first pops at E1). A sixth push is refused, with tx_ready low until the first frame ends. Output is 50·217 cycles of contiguous frames with no idle gap.
- With the FIFO holding 2 bytes, push on the same edge as the STOP→START pop → fifo_count stays 2, and no byte is lost or duplicated.
- Assert rst during DATABIT bit 3 with 3 bytes queued → dataserial=1, fifo_count=0, tx_ready=1, tx_busy=0 after the reset edge. Nothing is transmitted until a new push.
- CLOCKS_PER_BIT=2 build, byte 0x3C → 20-cycle frame with correct bit order, and the bit counter never exceeds 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants,
// common to the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        START   = 2'b01,
        DATABIT = 2'b10,
        STOP    = 2'b11
    } uart_state_e;

    localparam int DEFAULT_CLOCKS_PER_BIT = 217;  // 25 MHz / 115200 bps
    localparam int DATA_BITS              = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with count/full/empty. The head entry is visible
// combinationally on rd_data_o so a pop can load it on the same edge.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             wr, rd;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Full/empty guards make the FIFO safe even if the caller ignores them.
    assign wr = wr_en_i && !full_o;
    assign rd = rd_en_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({wr, rd})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO in front of a bit-timed serialiser.
// Frames are sent LSB first; queued bytes go out back-to-back.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          dataserial,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int                CNT_W   = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0]        IDX_MAX = 3'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 line_q;
    logic                 busy_q;

    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop, bit_end;

    assign tx_ready   = !fifo_full;
    assign push       = tx_valid && tx_ready;
    assign bit_end    = (cnt_q == CNT_MAX);
    // Pop from IDLE, or at the end of STOP so the next start bit follows
    // with no idle gap.
    assign pop        = !fifo_empty &&
                        ((state_q == IDLE) || (state_q == STOP && bit_end));
    assign dataserial = line_q;
    assign tx_busy    = busy_q;

    uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (tx_data),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Frame FSM: bit timer, bit index, shift register and registered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (pop) begin
                        state_q <= START;
                        shift_q <= head;
                        line_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= DATABIT;
                        line_q  <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATABIT: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_MAX) begin
                            state_q <= STOP;
                            line_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + 3'd1;
                            line_q <= shift_q[idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (pop) begin
                            state_q <= START;
                            shift_q <= head;
                            line_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            line_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a scoreboard queue of accepted bytes is
// compared against the serial line, frame by frame and cycle by cycle.
module tb_uart_transmitter;
    localparam int CPB  = 217;
    localparam int CPB2 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] da, db;
    logic       va, vb;
    logic       ready_a, line_a, busy_a;
    logic       ready_b, line_b, busy_b;
    logic [2:0] cnt_a, cnt_b;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    uart_transmitter #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .tx_data(da), .tx_valid(va), .tx_ready(ready_a),
        .dataserial(line_a), .tx_busy(busy_a), .fifo_count(cnt_a)
    );

    uart_transmitter #(.CLOCKS_PER_BIT(CPB2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .tx_data(db), .tx_valid(vb), .tx_ready(ready_b),
        .dataserial(line_b), .tx_busy(busy_b), .fifo_count(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte for exactly one edge; it must be accepted.
    task automatic push_a(input logic [7:0] b);
        chk("push_ready", 32'(ready_a), 32'd1);
        da = b;
        va = 1'b1;
        step();
        va = 1'b0;
        q.push_back(b);
    endtask

    // Check one whole frame of byte b, starting at the first start-bit
    // cycle minus 'skip' cycles already elapsed. Optionally offer a byte
    // on the final edge of the frame (the STOP->START pop edge).
    task automatic frame(input bit sel, input logic [7:0] b, input int skip,
                         input bit pe, input logic [7:0] pb);
        int cpb;
        logic [9:0] f;
        cpb = sel ? CPB2 : CPB;
        f = 10'h200 | (10'(b) << 1);
        for (int k = 0; k < 10; k++) begin
            bit ok;
            ok = 1'b1;
            for (int c = 0; c < cpb; c++) begin
                logic ln, bz;
                bit last;
                if (k * cpb + c < skip) continue;
                ln = sel ? line_b : line_a;
                bz = sel ? busy_b : busy_a;
                if (ln !== f[k] || bz !== 1'b1) ok = 1'b0;
                last = pe && (k == 9) && (c == cpb - 1);
                if (last) begin
                    chk("end_push_ready", 32'(ready_a), 32'd1);
                    da = pb;
                    va = 1'b1;
                end
                step();
                if (last) begin
                    va = 1'b0;
                    q.push_back(pb);
                end
            end
            chk($sformatf("%s_%02h_bit%0d", sel ? "b" : "a", b, k), 32'(ok), 32'd1);
        end
    endtask

    task automatic idle_a(input string tag);
        chk({tag, "_line"}, 32'(line_a), 32'd1);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    endtask

    // Push L bytes on consecutive edges, then check all L frames contiguous.
    task automatic burst(input string tag, input int n, input logic [7:0] bytes [4]);
        int el;
        for (int i = 0; i < n; i++) push_a(bytes[i]);
        el = n - 2;
        if (n == 1) begin
            step();
            el = 0;
        end
        chk({tag, "_count"}, 32'(cnt_a), 32'(n - 1));
        for (int i = 0; i < n; i++) frame(1'b0, q.pop_front(), (i == 0) ? el : 0, 1'b0, 8'h00);
        idle_a(tag);
    endtask

    initial begin
        logic [7:0] bytes [4];
        logic [7:0] b0;
        int el;
        bit ok;

        rst = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_line_a", 32'(line_a), 32'd1);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_count_a", 32'(cnt_a), 32'd0);
        chk("rst_ready_a", 32'(ready_a), 32'd1);
        chk("rst_line_b", 32'(line_b), 32'd1);
        repeat (5) step();
        idle_a("pre_idle");

        // Single byte 0xA5: line falls one edge after acceptance, 10 bits
        push_a(8'hA5);
        step();
        frame(1'b0, q.pop_front(), 0, 1'b0, 8'h00);
        idle_a("a5_done");
        repeat (5) step();
        idle_a("a5_idle");

        // Pattern bytes back-to-back
        bytes = '{8'h00, 8'hFF, 8'h55, 8'h80};
        burst("loop", 4, bytes);

        // Five pushes: fills FIFO, sixth refused until first frame ends
        push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44); push_a(8'h99);
        el = 3;
        chk("full_count", 32'(cnt_a), 32'd4);
        chk("full_ready", 32'(ready_a), 32'd0);
        da = 8'hEE;
        va = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            step();
            if (ready_a !== 1'b0) ok = 1'b0;
        end
        va = 1'b0;
        el += 3;
        chk("full_refuse_ready", 32'(ok), 32'd1);
        chk("full_refuse_count", 32'(cnt_a), 32'd4);
        frame(1'b0, q.pop_front(), el, 1'b0, 8'h00);
        chk("full_after_pop_count", 32'(cnt_a), 32'd3);
        chk("full_after_pop_ready", 32'(ready_a), 32'd1);
        for (int i = 0; i < 4; i++) frame(1'b0, q.pop_front(), 0, 1'b0, 8'h00);
        idle_a("full_done");
        chk("full_q_empty", 32'(q.size()), 32'd0);

        // Push on the same edge as the STOP->START pop
        push_a(8'h5A); push_a(8'h3D); push_a(8'hB7);
        chk("same_count_pre", 32'(cnt_a), 32'd2);
        frame(1'b0, q.pop_front(), 1, 1'b1, 8'hC3);
        chk("same_count_post", 32'(cnt_a), 32'd2);
        for (int i = 0; i < 3; i++) frame(1'b0, q.pop_front(), 0, 1'b0, 8'h00);
        idle_a("same_done");
        chk("same_q_empty", 32'(q.size()), 32'd0);

        // Reset in the middle of data bit 3 with 3 bytes queued
        push_a(8'h6B); push_a(8'h01); push_a(8'h02); push_a(8'h03);
        el = 2;
        chk("rmid_count", 32'(cnt_a), 32'd3);
        b0 = q[0];
        repeat (4 * CPB + CPB / 2 - el) step();
        chk("rmid_bit3", 32'(line_a), 32'(b0[3]));
        rst = 1'b1;
        da = 8'h77;
        va = 1'b1;
        step();
        rst = 1'b0;
        va = 1'b0;
        q.delete();
        chk("rmid_line", 32'(line_a), 32'd1);
        chk("rmid_count0", 32'(cnt_a), 32'd0);
        chk("rmid_ready", 32'(ready_a), 32'd1);
        chk("rmid_busy", 32'(busy_a), 32'd0);
        ok = 1'b1;
        repeat (3 * CPB) begin
            if (line_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 3'd0) ok = 1'b0;
            step();
        end
        chk("rmid_quiet", 32'(ok), 32'd1);

        // Randomized bursts
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
            burst($sformatf("rnd%0d", r), n, bytes);
            repeat ($urandom_range(1, 20)) step();
        end
        chk("rnd_q_empty", 32'(q.size()), 32'd0);

        // Two-clock-per-bit build: 20-cycle frame of 0x3C
        chk("b_ready", 32'(ready_b), 32'd1);
        db = 8'h3C;
        vb = 1'b1;
        step();
        vb = 1'b0;
        step();
        frame(1'b1, 8'h3C, 0, 1'b0, 8'h00);
        chk("b_idle_line", 32'(line_b), 32'd1);
        chk("b_idle_busy", 32'(busy_b), 32'd0);
        chk("b_idle_count", 32'(cnt_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
